// File: rtl/miner_regbank.sv
// Byte-addressed register bank: 80-byte header, start/stop pulses, 64-bit nonce FIFO with read shadow.
// Reads return one cycle after the strobe; no backpressure (full FIFO drops nonces and flags overflow).
module miner_regbank #(
   parameter int HDR_BYTES  = 80,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [15:0]               int_address,
   input  logic [7:0]                int_wr_data,
   input  logic                      int_write,
   input  logic                      int_read,
   input  logic                      int_req,
   output logic                      int_gnt,
   output logic [7:0]                int_rd_data,
   output logic [8*HDR_BYTES-1:0]    hdr_out,
   output logic                      core_start,
   output logic                      core_stop,
   input  logic                      core_busy,
   input  logic [63:0]               nonce_in,
   input  logic                      nonce_valid
);

   localparam int          PW         = $clog2(FIFO_DEPTH);
   localparam logic [15:0] A_HDR_END  = 16'(HDR_BYTES);
   localparam logic [15:0] A_CTRL     = 16'h0050;
   localparam logic [15:0] A_STATUS   = 16'h0051;
   localparam logic [15:0] A_POP      = 16'h0058;
   localparam logic [PW:0] C_FULL     = (PW+1)'(FIFO_DEPTH);

   logic                   r_gnt;
   logic [7:0]             r_rd_data;
   logic [8*HDR_BYTES-1:0] r_hdr;
   logic                   r_start;
   logic                   r_stop;
   logic                   r_ovf;
   logic [63:0]            r_shadow;
   logic [63:0]            r_mem [FIFO_DEPTH];
   logic [PW-1:0]          r_wptr;
   logic [PW-1:0]          r_rptr;
   logic [PW:0]            r_count;

   logic                   w_wr;
   logic                   w_rd;
   logic                   w_hdr_we;
   logic                   w_ctrl_we;
   logic                   w_status_we;
   logic                   w_empty;
   logic                   w_full;
   logic                   w_pop;
   logic                   w_pop_ok;
   logic                   w_push_ok;
   logic                   w_ovf_set;
   logic                   w_in_shadow;
   logic [63:0]            w_pop_val;
   logic [7:0]             w_status;
   logic [7:0]             w_rd_byte;

   // Strobes count only under grant; a simultaneous write wins and the read is dropped.
   assign w_wr        = int_write & r_gnt;
   assign w_rd        = int_read & r_gnt & ~int_write;
   assign w_hdr_we    = w_wr & (int_address < A_HDR_END) & ~core_busy;
   assign w_ctrl_we   = w_wr & (int_address == A_CTRL);
   assign w_status_we = w_wr & (int_address == A_STATUS);

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == C_FULL);
   assign w_pop       = w_rd & (int_address == A_POP);
   assign w_pop_ok    = w_pop & ~w_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_push_ok   = nonce_valid & (~w_full | w_pop_ok);
   assign w_ovf_set   = nonce_valid & ~w_push_ok;
   assign w_pop_val   = w_empty ? 64'h0 : r_mem[r_rptr];
   assign w_in_shadow = (int_address[15:3] == 13'h000B);
   assign w_status    = {4'h0, r_ovf, w_full, w_empty, core_busy};

   always_comb begin
      w_rd_byte = 8'h00;
      if (int_address < A_HDR_END) begin
         for (int i = 0; i < HDR_BYTES; i++) begin
            if (int_address == 16'(i)) w_rd_byte = r_hdr[8*i +: 8];
         end
      end else if (int_address == A_STATUS) begin
         w_rd_byte = w_status;
      end else if (int_address == A_POP) begin
         w_rd_byte = w_pop_val[7:0];
      end else if (w_in_shadow) begin
         w_rd_byte = r_shadow[{int_address[2:0], 3'b000} +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_gnt     <= 1'b0;
         r_rd_data <= 8'h00;
         r_start   <= 1'b0;
         r_stop    <= 1'b0;
      end else begin
         r_gnt   <= int_req;
         r_start <= w_ctrl_we & int_wr_data[0] & ~int_wr_data[1];
         r_stop  <= w_ctrl_we & int_wr_data[1];
         if (w_rd) r_rd_data <= w_rd_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hdr <= '0;
      end else if (w_hdr_we) begin
         for (int i = 0; i < HDR_BYTES; i++) begin
            if (int_address == 16'(i)) r_hdr[8*i +: 8] <= int_wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr] <= nonce_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_shadow <= 64'h0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + PW'(1);
         if (w_pop_ok)  r_rptr <= r_rptr + PW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_pop) r_shadow <= w_pop_val;
         // Set beats clear when both happen together.
         if (w_ovf_set)        r_ovf <= 1'b1;
         else if (w_status_we) r_ovf <= 1'b0;
      end
   end

   assign int_gnt     = r_gnt;
   assign int_rd_data = r_rd_data;
   assign hdr_out     = r_hdr;
   assign core_start  = r_start;
   assign core_stop   = r_stop;

endmodule
